// File: rtl/tick_pkg.sv
// Shared types and default widths for the tick scheduler slice.
package tick_pkg;

  localparam int DIV_W_DEF = 16;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } tick_state_t;

endpackage

// File: rtl/tick_divider.sv
// Loadable period counter. While `advance` is high it steps once per cycle
// and raises `hit` in the step where it sits at period-1, wrapping to 0.
// `load` restarts the count from 0; a load and an advance in the same cycle
// count the load cycle as the first step, so a period of 1 hits immediately.
module tick_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             advance,
  input  logic [DIV_W-1:0] period,
  output logic             hit
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] base;

  // Step source (restarted on load) and combinational match against period-1
  always_comb begin
    base = load ? '0 : cnt;
    hit  = advance && (base == period - DIV_W'(1));
  end

  // Count up while advancing, wrap on match, clear on a held load
  always_ff @(posedge clock) begin
    if (reset)        cnt <= '0;
    else if (advance) cnt <= hit ? '0 : base + DIV_W'(1);
    else if (load)    cnt <= '0;
  end

endmodule

// File: rtl/tick_scheduler.sv
// Round-robin shared tick generator: grants one of two requesters, emits
// `count` one-cycle enables spaced `div` cycles apart, then pulses done.
module tick_scheduler import tick_pkg::*; #(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               abort,
  input  logic [1:0]         req_valid,
  input  logic [2*DIV_W-1:0] req_div,
  input  logic [2*CNT_W-1:0] req_count,
  output logic [1:0]         req_ready,
  output logic               tick,
  output logic               tick_owner,
  output logic               busy,
  output logic [1:0]         done,
  output logic               aborted
);

  tick_state_t      state;
  logic             last_served;
  logic [DIV_W-1:0] period_q;
  logic [CNT_W-1:0] remaining;

  logic             pri, gidx, accept, advance, hit;
  logic [1:0]       grant, owner_oh;
  logic [DIV_W-1:0] d_sel, p_in, div_period;
  logic [CNT_W-1:0] c_in;

  // Arbitration, request capture values and divider control
  always_comb begin
    pri        = ~last_served;
    gidx       = req_valid[pri] ? pri : ~pri;
    grant      = (|req_valid) ? (2'b01 << gidx) : 2'b00;
    req_ready  = (state == IDLE) ? grant : 2'b00;
    accept     = |(req_valid & req_ready);
    d_sel      = gidx ? req_div[2*DIV_W-1:DIV_W] : req_div[DIV_W-1:0];
    c_in       = gidx ? req_count[2*CNT_W-1:CNT_W] : req_count[CNT_W-1:0];
    p_in       = (d_sel == '0) ? DIV_W'(1) : d_sel;
    div_period = accept ? p_in : period_q;
    owner_oh   = tick_owner ? 2'b10 : 2'b01;
    // The accept cycle already counts as the first divider step so the first
    // tick lands `period` cycles after the accept edge.
    advance    = (accept && enable && (c_in != '0)) ||
                 ((state == RUN) && enable && !abort && (remaining != '0));
  end

  tick_divider #(.DIV_W(DIV_W)) u_div (
    .clock   (clock),
    .reset   (reset),
    .load    (accept),
    .advance (advance),
    .period  (div_period),
    .hit     (hit)
  );

  // Burst FSM with registered tick/busy/done/aborted/owner outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      last_served <= 1'b1;
      tick_owner  <= 1'b0;
      period_q    <= '0;
      remaining   <= '0;
      tick        <= 1'b0;
      busy        <= 1'b0;
      done        <= 2'b00;
      aborted     <= 1'b0;
    end else begin
      tick <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tick_owner <= gidx;
            period_q   <= p_in;
            busy       <= 1'b1;
            tick       <= hit;
            remaining  <= c_in - CNT_W'(hit);
            if (c_in == '0) begin
              state <= DONE;
              done  <= grant;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state   <= DONE;
            aborted <= 1'b1;
            done    <= owner_oh;
          end else if (enable) begin
            // Last tick has already been shown; finish one cycle after it
            if (remaining == '0) begin
              state <= DONE;
              done  <= owner_oh;
            end else if (hit) begin
              tick      <= 1'b1;
              remaining <= remaining - CNT_W'(1);
            end
          end
        end
        DONE: begin
          done        <= 2'b00;
          aborted     <= 1'b0;
          busy        <= 1'b0;
          last_served <= tick_owner;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: cycle-exact tick/done timing per burst.
module tb_tick_scheduler;

  localparam int DIV_W = 16;
  localparam int CNT_W = 8;

  logic               clock = 1'b0;
  logic               reset, enable, abort;
  logic [1:0]         req_valid;
  logic [2*DIV_W-1:0] req_div;
  logic [2*CNT_W-1:0] req_count;
  logic [1:0]         req_ready;
  logic               tick, tick_owner, busy, aborted;
  logic [1:0]         done;

  int checks = 0;
  int errors = 0;

  tick_scheduler #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .abort      (abort),
    .req_valid  (req_valid),
    .req_div    (req_div),
    .req_count  (req_count),
    .req_ready  (req_ready),
    .tick       (tick),
    .tick_owner (tick_owner),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  always #5 clock = ~clock;

  // Issues one request and records cycles E+1..E+n (E = accept edge).
  // pause cycles [ps, ps+pl) hold enable low; abort is high in cycle ab_at.
  task automatic run_burst(input int r, input int d, input int c, input int n,
                           input int ps, input int pl, input int ab_at,
                           output logic [1:0] gnt, output logic [63:0] tmask,
                           output logic [63:0] bmask, output int done_cyc,
                           output logic [1:0] dvec, output logic ab,
                           output logic own);
    tmask = '0; bmask = '0; done_cyc = 0; dvec = 2'b00; ab = 1'b0; own = 1'b0;
    req_valid = 2'b00;
    req_valid[r] = 1'b1;
    req_div[r*DIV_W +: DIV_W] = DIV_W'(d);
    req_count[r*CNT_W +: CNT_W] = CNT_W'(c);
    @(negedge clock);
    gnt = req_ready;
    @(posedge clock); #1;
    // Scramble the request after accept; the active burst must not see it
    req_valid = 2'b00;
    req_div   = '1;
    req_count = '1;
    for (int k = 1; k <= n; k++) begin
      enable = !(k >= ps && k < ps + pl);
      abort  = (k == ab_at);
      @(negedge clock);
      if (tick) tmask[k] = 1'b1;
      if (busy) bmask[k] = 1'b1;
      if (k == 1) own = tick_owner;
      if (done != 2'b00 && done_cyc == 0) begin
        done_cyc = k; dvec = done; ab = aborted;
      end
      @(posedge clock); #1;
    end
    enable = 1'b1;
    abort  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; abort = 1'b0;
    req_valid = 2'b00; req_div = '0; req_count = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({tick, busy, done, aborted, tick_owner} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got tick=%b busy=%b done=%b aborted=%b owner=%b want all 0",
               tick, busy, done, aborted, tick_owner);
    end
    checks++;
    if (req_ready !== 2'b00) begin
      errors++; $display("FAIL reset_ready_none got %b want 00", req_ready);
    end
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL reset_ready_both got %b want 01", req_ready);
    end
    req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL reset_ready_one got %b want 10", req_ready);
    end
    req_valid = 2'b00;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [1:0] g, dv; logic [63:0] tm, bm; int dc; logic ab, own;
    run_burst(0, 4, 3, 16, 99, 0, 0, g, tm, bm, dc, dv, ab, own);
    checks++;
    if (g !== 2'b01) begin errors++; $display("FAIL single_grant got %b want 01", g); end
    checks++;
    if (tm !== 64'h1110) begin errors++; $display("FAIL single_ticks got %h want %h", tm, 64'h1110); end
    checks++;
    if (dc !== 13) begin errors++; $display("FAIL single_done_cycle got %0d want 13", dc); end
    checks++;
    if (dv !== 2'b01 || ab !== 1'b0) begin
      errors++; $display("FAIL single_done_vec got done=%b aborted=%b want 01/0", dv, ab);
    end
    checks++;
    if (bm !== 64'h3FFE) begin errors++; $display("FAIL single_busy got %h want %h", bm, 64'h3FFE); end
    checks++;
    if (own !== 1'b0) begin errors++; $display("FAIL single_owner got %b want 0", own); end
  endtask

  task automatic test_edges();
    logic [1:0] g, dv; logic [63:0] tm, bm; int dc; logic ab, own;
    // div 0 behaves as period 1
    run_burst(1, 0, 2, 6, 99, 0, 0, g, tm, bm, dc, dv, ab, own);
    checks++;
    if (tm !== 64'h6) begin errors++; $display("FAIL div0_ticks got %h want 6", tm); end
    checks++;
    if (dc !== 3 || dv !== 2'b10) begin
      errors++; $display("FAIL div0_done got cycle %0d vec %b want 3/10", dc, dv);
    end
    checks++;
    if (own !== 1'b1) begin errors++; $display("FAIL div0_owner got %b want 1", own); end
    // count 0 finishes straight away
    run_burst(1, 5, 0, 4, 99, 0, 0, g, tm, bm, dc, dv, ab, own);
    checks++;
    if (tm !== 64'h0) begin errors++; $display("FAIL cnt0_ticks got %h want 0", tm); end
    checks++;
    if (dc !== 1 || bm !== 64'h2) begin
      errors++; $display("FAIL cnt0_done got cycle %0d busy %h want 1/2", dc, bm);
    end
  endtask

  task automatic test_pause();
    logic [1:0] g, dv; logic [63:0] tm, bm; int dc; logic ab, own;
    run_burst(0, 3, 2, 14, 2, 4, 0, g, tm, bm, dc, dv, ab, own);
    checks++;
    if (tm !== 64'h480) begin errors++; $display("FAIL pause_ticks got %h want 480", tm); end
    checks++;
    if (dc !== 11) begin errors++; $display("FAIL pause_done_cycle got %0d want 11", dc); end
  endtask

  task automatic test_abort();
    logic [1:0] g, dv; logic [63:0] tm, bm; int dc; logic ab, own;
    run_burst(0, 10, 5, 30, 99, 0, 25, g, tm, bm, dc, dv, ab, own);
    checks++;
    if (tm !== 64'h100400) begin errors++; $display("FAIL abort_ticks got %h want 100400", tm); end
    checks++;
    if (dc !== 26 || dv !== 2'b01 || ab !== 1'b1) begin
      errors++; $display("FAIL abort_done got cycle %0d vec %b aborted %b want 26/01/1", dc, dv, ab);
    end
  endtask

  task automatic test_contention();
    logic [1:0] gl [3];
    int ng = 0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    req_valid = 2'b11;
    req_div   = {16'd1, 16'd1};
    req_count = {8'd1, 8'd1};
    for (int i = 0; i < 3; i++) gl[i] = 2'b00;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (req_ready != 2'b00) begin
        checks++;
        if (!$onehot(req_ready)) begin
          errors++; $display("FAIL contention_onehot got %b want one-hot", req_ready);
        end
        if (ng < 3) gl[ng] = req_ready;
        ng++;
      end
      @(posedge clock); #1;
    end
    req_valid = 2'b00;
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (gl[0] !== 2'b01 || gl[1] !== 2'b10 || gl[2] !== 2'b01) begin
      errors++; $display("FAIL contention_order got %b %b %b want 01 10 01", gl[0], gl[1], gl[2]);
    end
  endtask

  task automatic test_mid_reset();
    logic [1:0] g, dv; logic [63:0] tm, bm; int dc; logic ab, own;
    // Serve requester 0 so priority moves to requester 1 before the reset
    run_burst(0, 1, 1, 4, 99, 0, 0, g, tm, bm, dc, dv, ab, own);
    req_valid = 2'b10;
    req_div   = {16'd4, 16'd4};
    req_count = {8'd3, 8'd3};
    @(negedge clock);
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL midrst_grant got %b want 10", req_ready); end
    @(posedge clock); #1;
    req_valid = 2'b00;
    repeat (5) begin
      @(posedge clock); #1;
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", busy); end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    req_valid = 2'b11;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 2'b00 || tick !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got busy=%b done=%b tick=%b want 0/00/0", busy, done, tick);
    end
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL midrst_priority got %b want 01", req_ready); end
    @(posedge clock); #1;
    req_valid = 2'b00;
    repeat (6) @(posedge clock);
    #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_edges();
    test_pause();
    test_abort();
    test_contention();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
